syn_fifo_pro: RTL and testbench
===============================

Name: syn_fifo_pro

Overview:
Parametrised synchronous FIFO, successor to the basic single-clock FIFO. Adds:
- a selectable read mode: standard registered read, or first-word fall-through (FWFT)
- a live occupancy count
- programmable almost-full and almost-empty flags
- a read-data valid strobe
- optional sticky overflow/underflow error flags

Used as the general-purpose buffer between same-clock producer/consumer blocks.

Parameters:
DATA_WIDTH, 8, word width in bits
ADDR_WIDTH, 4, address width; DEPTH = 2**ADDR_WIDTH words
FWFT, 0, read mode: 0 = standard registered read, 1 = first-word fall-through
AFULL_TH, DEPTH-2, almost_full asserts when data_count >= AFULL_TH (legal range 1..DEPTH)
AEMPTY_TH, 1, almost_empty asserts when data_count <= AEMPTY_TH (legal range 0..DEPTH-1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write request
data_in  in  DATA_WIDTH  write data
rd_en  in  1  read request / acknowledge
data_out  out  DATA_WIDTH  read data
data_valid  out  1  data_out holds a valid word
full  out  1  data_count == DEPTH
empty  out  1  data_count == 0
almost_full  out  1  threshold flag
almost_empty  out  1  threshold flag
data_count  out  ADDR_WIDTH+1  words stored
err_clr  in  1  clears sticky error flags (used only with FIFO_ERR_FLAG_EN)
overflow  out  1  sticky write-while-full error
underflow  out  1  sticky read-while-empty error

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. Deassertion is used as synchronised upstream.
- Reset values: pointers 0, data_count 0, data_out 0, data_valid 0, empty 1, full 0, almost_empty 1, almost_full 0 (unless AFULL_TH==0, which is illegal), overflow 0, underflow 0.
- Reset mid-operation: contents discarded logically; memory array is not cleared.
- Input sampling: wr_en and rd_en are sampled directly at the clock edge. There is no input retiming stage.
- Read acceptance: rd_acc = rd_en && !empty.
- Write acceptance: wr_acc = wr_en && (!full || rd_acc).
  - A write while full is accepted only together with an accepted read; count is unchanged.
  - A write while empty is never combined with a read. In FWFT mode the word becomes visible the next cycle.
- Storage: memory written at mem[wr_ptr] on wr_acc. Read-before-write semantics when wr_ptr == rd_ptr in the same cycle.
- Pointers: ADDR_WIDTH bits, wrap modulo DEPTH. wr_ptr increments on wr_acc; rd_ptr increments on rd_acc.
- data_count updates on each edge:
  - +1 on wr_acc only
  - -1 on rd_acc only
  - unchanged on both or neither
  - never exceeds DEPTH and never underflows
- Flags: all flags are combinational decodes of registered data_count. They change the cycle after the causing edge.
- FWFT=0 (standard read):
  - data_out <= mem[rd_ptr] on rd_acc; it holds otherwise.
  - data_valid is a one-cycle pulse in the cycle after rd_acc. Latency is 1 clock.
- FWFT=1 (fall-through):
  - data_out = mem[rd_ptr] combinationally whenever !empty; it is don't-care when empty.
  - data_valid = !empty.
  - rd_en acts as an acknowledge and pops the displayed word. Zero read latency.

Optional Feature:
Macro FIFO_ERR_FLAG_EN.
- Defined:
  - overflow is set on wr_en && !wr_acc.
  - underflow is set on rd_en && empty.
  - Both are sticky until err_clr (synchronous, one cycle) or reset.
  - If set and clear coincide, set wins.
- Not defined: overflow and underflow are tied to 0, err_clr is ignored, and no flops are inferred. The port list is identical in both builds.

Decomposition:
- Package syn_fifo_pkg holds:
  - read-mode constants MODE_STD = 0 and MODE_FWFT = 1
  - a constant function computing count width from ADDR_WIDTH
  - default threshold constants
- One sub-module, syn_fifo_mem: DATA_WIDTH x DEPTH register array with a synchronous write port and an asynchronous read port. Control and flags stay in the top level.

Test Plan (DATA_WIDTH=8, ADDR_WIDTH=2 so DEPTH=4, AFULL_TH=3, AEMPTY_TH=1):
- Reset, then write 0x11,0x22,0x33,0x44 on consecutive cycles:
  - data_count reads 1,2,3,4
  - almost_empty falls after count 2
  - almost_full rises at count 3
  - full at 4
  - a 5th write 0x55 is dropped; count stays 4; overflow=1 if FIFO_ERR_FLAG_EN
- FWFT=0, FIFO holds 0x11..0x44, assert rd_en 4 cycles: data_out = 0x11,0x22,0x33,0x44, each one cycle after its read, data_valid pulsing each cycle; then empty=1; a further rd_en sets underflow.
- FWFT=1, single write 0xA5: next cycle data_out=0xA5 and data_valid=1 with no rd_en; one rd_en pulse gives empty=1, data_valid=0.
- Full FIFO (0x11..0x44), wr_en=rd_en=1 with data_in 0x99: count stays 4, 0x11 is read, 0x99 is stored at the freed slot and is later read as the 4th word after 0x22,0x33,0x44 (pointer wrap checked).
- Empty FIFO, wr_en=rd_en=1 with 0x5A: only the write is accepted, count=1, underflow=1 if enabled; then pulse err_clr and check underflow=0.
- Assert rst_n low mid-burst with count 3: all outputs return to reset values asynchronously; after release, write 0x77 and read back 0x77.

Source files
------------

// File: rtl/syn_fifo_pkg.sv
// syn_fifo_pkg: shared read-mode constants, count width helper and default thresholds for syn_fifo_pro
package syn_fifo_pkg;
    localparam int MODE_STD  = 0;
    localparam int MODE_FWFT = 1;
    localparam int DEF_AFULL_MARGIN = 2;
    localparam int DEF_AEMPTY_TH    = 1;
    function automatic int count_width(input int addr_width);
        return addr_width + 1;
    endfunction
endpackage

// File: rtl/syn_fifo_mem.sv
// syn_fifo_mem: DATA_WIDTH x 2**ADDR_WIDTH register array, synchronous write, asynchronous read
module syn_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/syn_fifo_pro.sv
// syn_fifo_pro: single-clock FIFO with standard or FWFT read, occupancy count and threshold flags.
// Define FIFO_ERR_FLAG_EN to build the sticky overflow/underflow flags.
module syn_fifo_pro
    import syn_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FWFT       = MODE_STD,
    parameter int AFULL_TH   = (2**ADDR_WIDTH) - DEF_AFULL_MARGIN,
    parameter int AEMPTY_TH  = DEF_AEMPTY_TH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   data_count,
    input  logic                  err_clr,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    typedef logic [count_width(ADDR_WIDTH)-1:0] cnt_t;
    typedef logic [ADDR_WIDTH-1:0] ptr_t;

    ptr_t wr_ptr, rd_ptr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic rd_acc, wr_acc;

    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);

    assign full         = data_count == cnt_t'(DEPTH);
    assign empty        = data_count == '0;
    assign almost_full  = data_count >= cnt_t'(AFULL_TH);
    assign almost_empty = data_count <= cnt_t'(AEMPTY_TH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            data_count <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + ptr_t'(1);
            if (rd_acc) rd_ptr <= rd_ptr + ptr_t'(1);
            if (wr_acc != rd_acc) data_count <= wr_acc ? data_count + cnt_t'(1) : data_count - cnt_t'(1);
        end
    end

    syn_fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    generate
        if (FWFT == MODE_FWFT) begin : g_fwft
            // Head word is shown directly; zeroed while empty so stale memory never leaks out.
            assign data_out   = empty ? '0 : rd_data;
            assign data_valid = !empty;
        end else begin : g_std
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_out   <= '0;
                    data_valid <= 1'b0;
                end else begin
                    if (rd_acc) data_out <= rd_data;
                    data_valid <= rd_acc;
                end
            end
        end
    endgenerate

`ifdef FIFO_ERR_FLAG_EN
    // A new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (wr_en && !wr_acc) || (overflow && !err_clr);
            underflow <= (rd_en && empty) || (underflow && !err_clr);
        end
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif
endmodule

// File: tb/tb_syn_fifo_pro.sv
// tb_syn_fifo_pro: directed bench for standard and FWFT builds against a queue-based reference model
module tb_syn_fifo_pro;
`ifdef FIFO_ERR_FLAG_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif
    logic clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0, rd_en = 1'b0, err_clr = 1'b0;
    logic [7:0] data_in = '0;
    logic [7:0] dout0, dout1;
    logic dv0, dv1, full0, full1, empty0, empty1, af0, af1, ae0, ae1, ovf0, ovf1, unf0, unf1;
    logic [2:0] cnt0, cnt1;

    syn_fifo_pro #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .FWFT(0), .AFULL_TH(3), .AEMPTY_TH(1)) u_std (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(dout0), .data_valid(dv0), .full(full0), .empty(empty0),
        .almost_full(af0), .almost_empty(ae0), .data_count(cnt0),
        .err_clr(err_clr), .overflow(ovf0), .underflow(unf0));

    syn_fifo_pro #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .FWFT(1), .AFULL_TH(3), .AEMPTY_TH(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(dout1), .data_valid(dv1), .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1), .data_count(cnt1),
        .err_clr(err_clr), .overflow(ovf1), .underflow(unf1));

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of stored words plus the last word handed out in standard mode.
    byte unsigned m_q[$];
    logic [7:0] m_dout;
    logic m_dv, m_ovf, m_unf, rd_ok, wr_ok;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_dout = '0;
            m_dv = 1'b0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            rd_ok = rd_en && m_q.size() != 0;
            wr_ok = wr_en && (m_q.size() < 4 || rd_ok);
            if (ERR) begin
                m_ovf = (wr_en && !wr_ok) || (m_ovf && !err_clr);
                m_unf = (rd_en && m_q.size() == 0) || (m_unf && !err_clr);
            end
            m_dv = rd_ok;
            if (rd_ok) m_dout = m_q.pop_front();
            if (wr_ok) m_q.push_back(data_in);
        end
    end

    task automatic chk_inst(input string t, input logic [2:0] c, input logic f, input logic e,
                            input logic a_f, input logic a_e, input logic o, input logic u);
        int n;
        n = m_q.size();
        cmp({t, "_count"}, c, n);
        cmp({t, "_full"}, f, n == 4);
        cmp({t, "_empty"}, e, n == 0);
        cmp({t, "_afull"}, a_f, n >= 3);
        cmp({t, "_aempty"}, a_e, n <= 1);
        cmp({t, "_ovf"}, o, m_ovf);
        cmp({t, "_unf"}, u, m_unf);
    endtask

    always @(negedge clk) begin
        chk_inst("std", cnt0, full0, empty0, af0, ae0, ovf0, unf0);
        chk_inst("fwft", cnt1, full1, empty1, af1, ae1, ovf1, unf1);
        cmp("std_dout", dout0, m_dout);
        cmp("std_dv", dv0, m_dv);
        cmp("fwft_dv", dv1, m_q.size() != 0);
        if (m_q.size() != 0) cmp("fwft_dout", dout1, m_q[0]);
    end

    task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
        wr_en = w; data_in = d; rd_en = r; err_clr = c;
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
    endtask

    logic [7:0] wrap_exp [4] = '{8'h22, 8'h33, 8'h44, 8'h99};

    initial begin
        repeat (2) @(posedge clk);
        #1;
        cmp("rst_count", cnt0, 0); cmp("rst_empty", empty0, 1); cmp("rst_aempty", ae0, 1);
        cmp("rst_afull", af0, 0); cmp("rst_full", full0, 0); cmp("rst_dout", dout0, 0);
        cmp("rst_dv", dv0, 0); cmp("rst_fwft_dv", dv1, 0); cmp("rst_ovf", ovf0, 0); cmp("rst_unf", unf0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'(17 * (i + 1)), 1'b0, 1'b0);
            cmp("wr_count", cnt0, i + 1);
            cmp("wr_aempty", ae0, i == 0);
            cmp("wr_afull", af0, i >= 2);
            cmp("wr_full", full0, i == 3);
        end
        cmp("fwft_head", dout1, 8'h11);
        step(1'b1, 8'h55, 1'b0, 1'b0);
        cmp("drop_count", cnt0, 4);
        cmp("overflow", ovf0, ERR);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        cmp("ovf_clr", ovf0, 0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            cmp("rd_dout", dout0, 8'(17 * (i + 1)));
            cmp("rd_dv", dv0, 1);
        end
        cmp("drain_empty", empty0, 1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        cmp("underflow", unf0, ERR);
        cmp("rd_empty_dv", dv0, 0);
        cmp("rd_empty_hold", dout0, 8'h44);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        cmp("fwft_a5", dout1, 8'hA5);
        cmp("fwft_a5_dv", dv1, 1);
        cmp("std_no_dv", dv0, 0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        cmp("fwft_pop_empty", empty1, 1);
        cmp("fwft_pop_dv", dv1, 0);
        for (int i = 0; i < 4; i++) step(1'b1, 8'(17 * (i + 1)), 1'b0, 1'b0);
        step(1'b1, 8'h99, 1'b1, 1'b0);
        cmp("full_rw_count", cnt0, 4);
        cmp("full_rw_dout", dout0, 8'h11);
        cmp("full_rw_ovf", ovf0, 0);
        for (int i = 0; i < 4; i++) begin
            cmp("wrap_fwft", dout1, wrap_exp[i]);
            step(1'b0, 8'h00, 1'b1, 1'b0);
            cmp("wrap_dout", dout0, wrap_exp[i]);
        end
        cmp("wrap_empty", empty0, 1);
        step(1'b1, 8'h5A, 1'b1, 1'b0);
        cmp("empty_rw_count", cnt0, 1);
        cmp("empty_rw_unf", unf0, ERR);
        cmp("empty_rw_dv", dv0, 0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        cmp("unf_clr", unf0, 0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        cmp("pop_5a", dout0, 8'h5A);
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        cmp("pre_rst_count", cnt0, 3);
        #2 rst_n = 1'b0;
        #1;
        cmp("arst_count", cnt0, 0); cmp("arst_empty", empty0, 1); cmp("arst_full", full0, 0);
        cmp("arst_aempty", ae0, 1); cmp("arst_afull", af0, 0); cmp("arst_dout", dout0, 0);
        cmp("arst_dv", dv0, 0); cmp("arst_fwft_dv", dv1, 0); cmp("arst_fwft_count", cnt1, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1'b1, 8'h77, 1'b0, 1'b0);
        cmp("post_rst_fwft", dout1, 8'h77);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        cmp("post_rst_dout", dout0, 8'h77);
        cmp("post_rst_empty", empty0, 1);
        repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
